data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Handshaked, multi-cycle data-memory responder: the target side of the core's load/store port.
- Accepts one word read or write request from the datapath, inserts a programmable number of wait states, then returns read data or a write acknowledgement with an error flag.
- Sits between the core's load/store address/data signals and the word-array storage.
- Replaces the zero-latency combinational data memory, so the pipeline or stall logic can be exercised against realistic memory timing.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; byte range 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, wait cycles between request acceptance and response; 0 is legal.

Ports:
- clk  input  1  single system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store word, 0 = load word
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- resp_valid  output  1  response present
- resp_ready  input  1  requester consumes the response this cycle
- resp_rdata  output  32  load data; 0 for writes and errors
- resp_err  output  1  request was misaligned or out of range

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is sampled only on the rising edge of clk (synchronous, active-high).
  - While rst is high: state becomes IDLE, wait counter is 0, req_ready is 1, resp_valid is 0, resp_rdata is 0, resp_err is 0.
  - Storage contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid, the request is accepted at that edge (cycle T).
    - If LATENCY=0, go to RESP.
    - Otherwise load the counter with LATENCY-1 and go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle; go to RESP when the counter is 0.
  - RESP: resp_valid=1. Hold resp_rdata and resp_err stable until resp_ready=1, then go to IDLE on that edge.
- Latency: resp_valid first asserts in cycle T+1+LATENCY.
- Throughput: at most one request per LATENCY+2 cycles. There is no accept in the same cycle as a response handoff.
- Address check at acceptance:
  - err = (req_addr[1:0] != 0) or (req_addr >= 4*DEPTH_WORDS).
  - Word index = req_addr[clog2(DEPTH_WORDS)+1:2].
- Write:
  - When no error, the storage word is updated at the acceptance edge.
  - On error, storage is not modified.
  - resp_rdata is 0 in both cases.
- Read:
  - Data is captured at the acceptance edge into the response register.
  - A read returns the word value from before any same-edge change; none can occur because only one request is in flight.
  - On error, resp_rdata is 0.
- Request-side inputs: in WAIT and RESP, req_valid and all request fields are ignored. The requester must hold its request until req_ready.
- Reset mid-operation:
  - rst in WAIT or RESP aborts the transaction; the next cycle is IDLE and no response is produced.
  - A write accepted before reset remains committed.
- rst has priority over every other event in the same cycle.
- Widths:
  - Counter width is clog2(LATENCY+1), minimum 1.
  - Address comparison is unsigned, at 32 bits.

Decomposition:
- Shared package mem_bus_pkg:
  - State enum: IDLE, WAIT, RESP.
  - WORD_BYTES=4.
  - ADDR_W=32.
  - DATA_W=32.
  - Alignment mask constant 2'b00.
- One sub-module: mem_word_array (DEPTH_WORDS x 32). It has one synchronous write port and one read port; the read value is registered by the FSM.
- Address check and FSM stay in data_mem_responder.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0x00000000, resp_err=0.
- Write/read: LATENCY=2.
  - Write addr 0x00000010, data 0xDEADBEEF, accepted at T -> resp_valid at T+3 with resp_err=0 and resp_rdata=0.
  - Then read 0x00000010 -> resp_rdata=0xDEADBEEF at accept+3.
- Misaligned write: write 0x00000013, data 0x12345678 -> resp_err=1. A following read of 0x00000010 still returns 0xDEADBEEF.
- Out of range: read 0x00000400 with DEPTH_WORDS=256 -> resp_err=1, resp_rdata=0.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP, with req_valid=1 driving a new request:
  - resp_valid, resp_rdata and resp_err stay stable.
  - req_ready stays 0 and the new request is not accepted.
  - After resp_ready=1, req_ready=1 on the next cycle.
- Reset mid-WAIT: write 0x00000020, data 0xCAFEF00D, assert rst one cycle after acceptance:
  - No resp_valid is produced and the next cycle is IDLE.
  - A later read of 0x00000020 returns 0xCAFEF00D.
  - Repeat with LATENCY=0: response is in cycle T+1.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    // Low address bits must match this for a word-aligned access
    localparam logic [1:0] ALIGN_MASK = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Word-index width, never narrower than one bit
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Load/store request/response bus between core and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    import mem_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_word_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_array
// Description : Word storage with one synchronous write port and one
//               asynchronous read port; contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_word_array
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [IDX_W-1:0]  i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [IDX_W-1:0]  i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Store a word on the write-enable edge
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Handshaked word memory target with programmable wait states,
//               address checking and a registered response.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(WORD_BYTES * DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              w_accept;
    logic              w_addr_err;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_mem_rdata;

    // Reset wins over acceptance, so a write is only committed outside reset
    assign w_accept   = (state_q == IDLE) && bus.req_valid && !rst;
    assign w_addr_err = (bus.req_addr[1:0] != ALIGN_MASK) || (bus.req_addr >= BYTE_LIMIT);
    assign w_idx      = bus.req_addr[IDX_W+1:2];
    assign w_mem_we   = w_accept && bus.req_write && !w_addr_err;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_idx),
        .i_wdata (bus.req_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_mem_rdata)
    );

    // Next-state and registered-output computation for the handshake FSM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    err_d       = w_addr_err;
                    rdata_d     = (bus.req_write || w_addr_err) ? '0 : w_mem_rdata;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = '0;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                rdata_d      = '0;
                err_d        = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
`default_nettype wire
